// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous FIFO.
// Pointers carry one extra wrap bit above the storage index.
package fifo_pkg;

    localparam int FIFO_DEPTH      = 8;
    localparam int FIFO_DATA_WIDTH = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: index in the low bits, wrap flag in the MSB.
// A plain binary increment rolls the index and toggles the wrap bit together.
module fifo_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// Overflow writes and underflow reads are dropped; flags decode from registered pointers.
module synchronous_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Gating uses the pre-edge flags, so full+read+write pops only.
    assign wr_fire = w_en & ~full;
    assign rd_fire = r_en & ~empty;

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_fire),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_fire),
        .ptr   (rd_ptr)
    );

    // Storage is deliberately not reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign data_out = empty ? '0 : mem_q[rd_idx];

endmodule

// File: tb/tb_synchronous_fifo.sv
// Randomized self-checking bench for synchronous_fifo against a queue model.
module tb_synchronous_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];

    synchronous_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [DW-1:0] exp_dout();
        if (model_q.size() == 0) return '0;
        return model_q[0];
    endfunction

    // Drive one cycle of stimulus and advance the model by the FIFO rules.
    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d);
        bit wr_ok;
        bit rd_ok;
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        if (rst_n) begin
            wr_ok = w && (model_q.size() < DEPTH);
            rd_ok = r && (model_q.size() > 0);
            if (rd_ok) void'(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
        end
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_q.delete();
        for (int i = 0; i < 10; i++) begin
            drive(i[0], ~i[0], DW'($urandom));
            checks++;
            if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: empty=%b full=%b dout=%h want 1 0 00",
                         i, empty, full, data_out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, '0);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_release: empty=%b full=%b dout=%h want 1 0 00",
                     empty, full, data_out);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] want;
        for (int i = 1; i <= DEPTH; i++) begin
            want = DW'(i * 8'h11);
            drive(1'b1, 1'b0, want);
            checks++;
            if (data_out !== 8'h11 || full !== (i == DEPTH) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_write %0d: dout=%h full=%b empty=%b want 11 %b 0",
                         i, data_out, full, empty, (i == DEPTH));
            end
        end
        drive(1'b1, 1'b0, 8'h99);
        checks++;
        if (full !== 1'b1 || data_out !== 8'h11) begin
            errors++;
            $display("FAIL overflow_ignored: full=%b dout=%h want 1 11", full, data_out);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            want = DW'(i * 8'h11);
            checks++;
            if (data_out !== want) begin
                errors++;
                $display("FAIL drain_order %0d: dout=%h want %h", i, data_out, want);
            end
            drive(1'b0, 1'b1, '0);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b full=%b dout=%h want 1 0 00",
                     empty, full, data_out);
        end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, '0);
            checks++;
            if (empty !== 1'b1 || data_out !== '0) begin
                errors++;
                $display("FAIL underflow %0d: empty=%b dout=%h want 1 00", i, empty, data_out);
            end
        end
        drive(1'b1, 1'b0, 8'hA5);
        checks++;
        if (data_out !== 8'hA5 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fwft_after_underflow: dout=%h empty=%b want a5 0", data_out, empty);
        end
        drive(1'b0, 1'b1, '0);
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL single_pop_empty: empty=%b want 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03);
        drive(1'b1, 1'b1, 8'h04);
        checks++;
        if (data_out !== 8'h02 || model_q.size() != 3) begin
            errors++;
            $display("FAIL simul_mid: dout=%h want 02", data_out);
        end
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (data_out !== DW'(i)) begin
                errors++;
                $display("FAIL simul_drain %0d: dout=%h want %h", i, data_out, DW'(i));
            end
            drive(1'b0, 1'b1, '0);
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_drained_empty: empty=%b want 1", empty);
        end
        drive(1'b1, 1'b1, 8'h5C);
        checks++;
        if (data_out !== 8'h5C || empty !== 1'b0) begin
            errors++;
            $display("FAIL simul_on_empty: dout=%h empty=%b want 5c 0", data_out, empty);
        end
        for (int i = 1; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(8'hC0 + i));
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL simul_prefull: full=%b want 1", full);
        end
        drive(1'b1, 1'b1, 8'hEE);
        checks++;
        if (full !== 1'b0 || data_out !== 8'hC1 || model_q.size() != DEPTH - 1) begin
            errors++;
            $display("FAIL simul_on_full: full=%b dout=%h want 0 c1", full, data_out);
        end
        while (model_q.size() > 0) begin
            checks++;
            if (data_out !== exp_dout()) begin
                errors++;
                $display("FAIL simul_full_drain: dout=%h want %h", data_out, exp_dout());
            end
            drive(1'b0, 1'b1, '0);
        end
    endtask

    task automatic test_random_traffic();
        bit w;
        bit r;
        for (int c = 0; c < 10; c++) begin
            drive(~c[0], 1'b0, DW'($urandom));
        end
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 30; c++) begin
                checks++;
                if (data_out !== exp_dout() || empty !== (model_q.size() == 0) ||
                    full !== (model_q.size() == DEPTH)) begin
                    errors++;
                    $display("FAIL burst %0d cyc %0d: dout=%h e=%b f=%b want %h %b %b",
                             b, c, data_out, empty, full, exp_dout(),
                             (model_q.size() == 0), (model_q.size() == DEPTH));
                end
                drive(~c[0], ~c[0], DW'($urandom));
            end
        end
        // Skewed random phases push occupancy to both ends over many wraps.
        for (int c = 0; c < 400; c++) begin
            if (c < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 1) != 0);
            end else begin
                w = ($urandom_range(0, 1) != 0);
                r = ($urandom_range(0, 3) != 0);
            end
            checks++;
            if (data_out !== exp_dout() || empty !== (model_q.size() == 0) ||
                full !== (model_q.size() == DEPTH)) begin
                errors++;
                $display("FAIL random cyc %0d: dout=%h e=%b f=%b want %h %b %b",
                         c, data_out, empty, full, exp_dout(),
                         (model_q.size() == 0), (model_q.size() == DEPTH));
            end
            drive(w, r, DW'($urandom));
        end
        while (model_q.size() > 0) drive(1'b0, 1'b1, '0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h30 + i));
        #3;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: empty=%b full=%b dout=%h want 1 0 00",
                     empty, full, data_out);
        end
        #2;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h7E);
        checks++;
        if (data_out !== 8'h7E || empty !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_post_write: dout=%h empty=%b want 7e 0", data_out, empty);
        end
        drive(1'b0, 1'b1, '0);
        checks++;
        if (empty !== 1'b1 || data_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_post_read: empty=%b dout=%h want 1 00", empty, data_out);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_underflow();
        test_simultaneous();
        test_random_traffic();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
